// File: rtl/ppu_pkg.sv
// Shared PPU constants: bus widths, region map and DMA writer FSM states.
// Region bases describe the 12-bit PPU word address map.
package ppu_pkg;

  localparam int PPU_ADDR_W = 12;
  localparam int PPU_DATA_W = 32;

  localparam logic [PPU_ADDR_W-1:0] PPU_TILE_BUF_BASE = 12'h000;
  localparam logic [PPU_ADDR_W-1:0] PPU_TILE_GFX_BASE = 12'h400;
  localparam logic [PPU_ADDR_W-1:0] PPU_SPR_GFX_BASE  = 12'h800;
  localparam logic [PPU_ADDR_W-1:0] PPU_PALETTE_BASE  = 12'hC00;
  localparam logic [PPU_ADDR_W-1:0] PPU_OAM_BASE      = 12'hE00;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    XFER,
    FINISH
  } dma_state_t;

  function automatic logic in_oam(input logic [PPU_ADDR_W-1:0] a);
    return a >= PPU_OAM_BASE;
  endfunction

endpackage

// File: rtl/ppu_dma_writer.sv
// Streams ready/valid words into consecutive PPU addresses.
// Define PPU_DMA_VBLANK_GATE_EN to gate transfers on vblank.
module ppu_dma_writer
  import ppu_pkg::*;
#(
  parameter int ADDR_W = PPU_ADDR_W,
  parameter int DATA_W = PPU_DATA_W,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic              vblank,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              write,
  output logic              chipselect,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  dma_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;
  logic              empty_q;
  logic              gate_open;
  logic              handshake;

`ifdef PPU_DMA_VBLANK_GATE_EN
  assign gate_open = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_open     = 1'b1;
`endif

  assign src_ready = (state == XFER) && gate_open;
  assign busy      = (state != IDLE);
  assign handshake = src_valid & src_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      empty_q    <= 1'b0;
      address    <= '0;
      write_data <= '0;
      write      <= 1'b0;
      chipselect <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      write      <= 1'b0;
      chipselect <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ptr       <= base_addr;
            remaining <= length;
            empty_q   <= (length == '0);
            state     <= ARM;
          end
        end
        ARM: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else if (remaining == '0) begin
            // Empty transfer: done shows while FINISH is busy.
            done  <= 1'b1;
            state <= FINISH;
          end else if (gate_open) begin
            state <= XFER;
          end
        end
        XFER: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else if (handshake) begin
            write      <= 1'b1;
            chipselect <= 1'b1;
            write_data <= src_data;
            address    <= ptr;
            ptr        <= ptr + 1'b1;
            remaining  <= remaining - 1'b1;
            if (remaining == LEN_W'(1))
              state <= FINISH;
          end
        end
        FINISH: begin
          // Final bus write is on the bus now; done follows it.
          done  <= !empty_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
